// File: rtl/clk_div_cfg_pkg.sv
// Shared types and helpers for the clock-divider configuration controller.
package clk_div_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    ACK    = 3'd4
  } state_t;

  localparam logic [7:0] CLK_DIV_DEFAULT_RATIO = 8'd1;

  // Divided clock needs two output periods to settle; ratios 0 and 1 are bypass.
  function automatic int unsigned settle_cycles(input int unsigned ratio);
    return (ratio <= 32'd1) ? 32'd2 : 32'd2 * ratio;
  endfunction

endpackage

// File: rtl/clk_div_rr_arb.sv
// Two-way round-robin arbiter; combinational grant, priority pointer advances on strobe.
// After an advance, the requester that was not just served has priority.
module clk_div_rr_arb (
  input  logic       i_ref_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       adv_id,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_q;

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (req[0] && (!ptr_q || !req[1])) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant    = 2'b10;
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr_q <= 1'b0;
    end else if (adv) begin
      ptr_q <= ~adv_id;
    end
  end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Arbitrates two ratio-change requesters and sequences the divider: gate off, load, re-enable, settle, ack.
// All outputs are registered from the next state, so they line up with the state they describe.
module clk_div_cfg_ctrl
  import clk_div_cfg_pkg::*;
#(
  parameter int                  RATIO_WD      = 8,
  parameter logic [RATIO_WD-1:0] DEFAULT_RATIO = RATIO_WD'(CLK_DIV_DEFAULT_RATIO),
  parameter int                  DRAIN_CYC     = 2
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_req0,
  input  logic [RATIO_WD-1:0] i_ratio0,
  output logic                o_ack0,
  input  logic                i_req1,
  input  logic [RATIO_WD-1:0] i_ratio1,
  output logic                o_ack1,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic                o_busy,
  output logic                o_grant_id
);

  localparam int CNT_WD = RATIO_WD + 1;

  state_t              state_q, state_d;
  logic [RATIO_WD-1:0] shadow_q, shadow_d, ratio_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                fast_q, fast_d;
  logic                grant_id_d, clk_en_d, busy_d, ack0_d, ack1_d;
  logic [1:0]          arb_req, arb_grant;
  logic                arb_id, arb_adv;

  assign arb_req = {i_req1, i_req0};

  clk_div_rr_arb u_arb (
    .i_ref_clk (i_ref_clk),
    .i_rst     (i_rst),
    .req       (arb_req),
    .adv       (arb_adv),
    .adv_id    (o_grant_id),
    .grant     (arb_grant),
    .grant_id  (arb_id)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    ratio_d    = o_div_ratio;
    cnt_d      = cnt_q;
    fast_d     = fast_q;
    grant_id_d = o_grant_id;
    arb_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          grant_id_d = arb_id;
          shadow_d   = arb_id ? i_ratio1 : i_ratio0;
          fast_d     = (shadow_d == o_div_ratio);
          cnt_d      = CNT_WD'(DRAIN_CYC - 1);
          state_d    = DRAIN;
        end
      end
      // A fast-path request passes through DRAIN for one cycle with the enable left alone.
      DRAIN: begin
        if (fast_q) begin
          state_d = ACK;
        end else if (cnt_q == '0) begin
          ratio_d = shadow_q;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = CNT_WD'(settle_cycles(32'(shadow_q)) - 32'd1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        arb_adv = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clk_en_d = 1'b0;
    case (state_d)
      IDLE, SETTLE, ACK: clk_en_d = i_enable;
      DRAIN:             clk_en_d = i_enable & fast_d;
      default:           clk_en_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
    ack0_d = (state_d == ACK) && !grant_id_d;
    ack1_d = (state_d == ACK) && grant_id_d;
  end

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      shadow_q    <= DEFAULT_RATIO;
      cnt_q       <= '0;
      fast_q      <= 1'b0;
      o_div_ratio <= DEFAULT_RATIO;
      o_clk_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_grant_id  <= 1'b0;
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      fast_q      <= fast_d;
      o_div_ratio <= ratio_d;
      o_clk_en    <= clk_en_d;
      o_busy      <= busy_d;
      o_grant_id  <= grant_id_d;
      o_ack0      <= ack0_d;
      o_ack1      <= ack1_d;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: table of single-request vectors plus hand-written multi-cycle sequences.
module tb_clk_div_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] ratio0 = 8'd0, ratio1 = 8'd0;
  logic       ack0, ack1, clk_en, busy, gid;
  logic [7:0] div_ratio;

  int n_chk = 0;
  int n_err = 0;

  clk_div_cfg_ctrl #(.RATIO_WD(8), .DEFAULT_RATIO(8'd1), .DRAIN_CYC(2)) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst_n),
    .i_enable    (en),
    .i_req0      (req0),
    .i_ratio0    (ratio0),
    .o_ack0      (ack0),
    .i_req1      (req1),
    .i_ratio1    (ratio1),
    .o_ack1      (ack1),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_grant_id  (gid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r1;
    logic [7:0] ratio;
    int         lat;
    bit         drop;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Counts posedges until the expected ack is seen at a negedge; bounded.
  task automatic wait_ack(input bit id, output int lat, output bit saw_lo, output bit saw_hi,
                          output bit gbad, output bit other);
    bit done;
    done = 1'b0; lat = 0; saw_lo = 1'b0; saw_hi = 1'b0; gbad = 1'b0; other = 1'b0;
    while (!done && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (clk_en !== 1'b1) saw_lo = 1'b1; else saw_hi = 1'b1;
      if (busy && gid !== id) gbad = 1'b1;
      if ((id ? ack0 : ack1) !== 1'b0) other = 1'b1;
      if ((id ? ack1 : ack0) === 1'b1) done = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit lo, hi, gb, oth;
    bit ack_seen;

    vecs[0] = '{1'b0, 8'd4, 12, 1'b1};
    vecs[1] = '{1'b1, 8'd4,  2, 1'b0};
    vecs[2] = '{1'b1, 8'd0,  6, 1'b1};
    vecs[3] = '{1'b0, 8'd1,  6, 1'b1};
    vecs[4] = '{1'b1, 8'd3, 10, 1'b1};
    vecs[5] = '{1'b0, 8'd3,  2, 1'b0};

    // Reset state
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ratio", 32'(div_ratio), 32'd1);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_clk_en", 32'(clk_en), 32'd1);
    chk("idle_ratio", 32'(div_ratio), 32'd1);
    chk("idle_acks", 32'({ack1, ack0}), 32'd0);

    // Simultaneous requests; req0 held through its ack must yield to waiting req1
    req0 = 1'b1; ratio0 = 8'd6;
    req1 = 1'b1; ratio1 = 8'd3;
    wait_ack(1'b0, lat, lo, hi, gb, oth);
    chk("sim_r0_lat", 32'(lat), 32'd16);
    chk("sim_r0_ratio", 32'(div_ratio), 32'd6);
    chk("sim_r0_gid", 32'(gb), 32'd0);
    chk("sim_r0_overlap", 32'(oth), 32'd0);
    wait_ack(1'b1, lat, lo, hi, gb, oth);
    chk("sim_r1_lat", 32'(lat), 32'd11);
    chk("sim_r1_ratio", 32'(div_ratio), 32'd3);
    chk("sim_r1_gid", 32'(gb), 32'd0);
    chk("sim_r1_overlap", 32'(oth), 32'd0);
    req1 = 1'b0;
    wait_ack(1'b0, lat, lo, hi, gb, oth);
    chk("held_r0_lat", 32'(lat), 32'd17);
    chk("held_r0_ratio", 32'(div_ratio), 32'd6);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sim_done_busy", 32'(busy), 32'd0);

    // Table-driven single requests
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].r1) begin
        req1 = 1'b1; ratio1 = vecs[i].ratio;
      end else begin
        req0 = 1'b1; ratio0 = vecs[i].ratio;
      end
      wait_ack(vecs[i].r1, lat, lo, hi, gb, oth);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_ratio", i), 32'(div_ratio), 32'(vecs[i].ratio));
      chk($sformatf("v%0d_clk_drop", i), 32'(lo), 32'(vecs[i].drop));
      chk($sformatf("v%0d_gid", i), 32'(gb), 32'd0);
      chk($sformatf("v%0d_other_ack", i), 32'(oth), 32'd0);
      chk($sformatf("v%0d_busy_at_ack", i), 32'(busy), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_ack_width", i), 32'({ack1, ack0}), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset during SETTLE of ratio 10, request held across reset
    req0 = 1'b1; ratio0 = 8'd10;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_settle_ratio", 32'(div_ratio), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("midrst_ratio", 32'(div_ratio), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_clk_en", 32'(clk_en), 32'd0);
    ack_seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 !== 1'b0 || ack1 !== 1'b0) ack_seen = 1'b1;
    end
    chk("midrst_no_ack", 32'(ack_seen), 32'd0);
    rst_n = 1'b1;
    wait_ack(1'b0, lat, lo, hi, gb, oth);
    chk("rst_reserve_lat", 32'(lat), 32'd24);
    chk("rst_reserve_ratio", 32'(div_ratio), 32'd10);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Enable dropped during DRAIN of ratio 2, request also dropped after grant
    req0 = 1'b1; ratio0 = 8'd2;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    req0 = 1'b0;
    wait_ack(1'b0, lat, lo, hi, gb, oth);
    chk("en_lo_lat", 32'(lat), 32'd7);
    chk("en_lo_clk_en_hi", 32'(hi), 32'd0);
    chk("en_lo_ratio", 32'(div_ratio), 32'd2);
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("en_restore_clk_en", 32'(clk_en), 32'd1);
    chk("en_restore_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
